// File: rtl/afu_req_shim_if.sv
// afu_req_shim_if: user-side request/response and CCI TX/RX signal bundle for afu_req_shim.
//   slave  : the shim's view (takes user requests and CCI RX, drives CCI TX and user responses)
//   master : the opposite side (user logic plus CCI model)
//   usr_rd_req_* / usr_wr_req_*        : user read/write requests and almostfull back-pressure
//   usr_rd_rsp_* / usr_wr_rsp0/1_*     : user responses, registered copies of the RX inputs
//   tx0_* / tx1_*                      : CCI read/write requests and the CCI almostfull inputs
//   rx0_* / rx1_*                      : CCI responses
interface afu_req_shim_if #(
    parameter int unsigned ADDR_LMT    = 20,
    parameter int unsigned MDATA       = 14,
    parameter int unsigned CACHE_WIDTH = 512
);
    logic [ADDR_LMT-1:0]    usr_rd_req_addr;
    logic [MDATA-1:0]       usr_rd_req_mdata;
    logic                   usr_rd_req_en;
    logic                   usr_rd_req_almostfull;
    logic [ADDR_LMT-1:0]    usr_wr_req_addr;
    logic [MDATA-1:0]       usr_wr_req_mdata;
    logic [CACHE_WIDTH-1:0] usr_wr_req_data;
    logic                   usr_wr_req_en;
    logic                   usr_wr_req_almostfull;

    logic                   usr_rd_rsp_valid;
    logic [MDATA-1:0]       usr_rd_rsp_mdata;
    logic [CACHE_WIDTH-1:0] usr_rd_rsp_data;
    logic                   usr_wr_rsp0_valid;
    logic [MDATA-1:0]       usr_wr_rsp0_mdata;
    logic                   usr_wr_rsp1_valid;
    logic [MDATA-1:0]       usr_wr_rsp1_mdata;

    logic                   tx0_valid;
    logic [31:0]            tx0_addr;
    logic [MDATA-1:0]       tx0_mdata;
    logic                   tx0_almostfull;
    logic                   tx1_valid;
    logic [31:0]            tx1_addr;
    logic [MDATA-1:0]       tx1_mdata;
    logic [CACHE_WIDTH-1:0] tx1_data;
    logic                   tx1_almostfull;

    logic                   rx0_rd_valid;
    logic                   rx0_wr_valid;
    logic [MDATA-1:0]       rx0_mdata;
    logic [CACHE_WIDTH-1:0] rx0_data;
    logic                   rx1_wr_valid;
    logic [MDATA-1:0]       rx1_mdata;

    modport slave (
        input  usr_rd_req_addr, usr_rd_req_mdata, usr_rd_req_en,
        output usr_rd_req_almostfull,
        input  usr_wr_req_addr, usr_wr_req_mdata, usr_wr_req_data, usr_wr_req_en,
        output usr_wr_req_almostfull,
        output usr_rd_rsp_valid, usr_rd_rsp_mdata, usr_rd_rsp_data,
        output usr_wr_rsp0_valid, usr_wr_rsp0_mdata, usr_wr_rsp1_valid, usr_wr_rsp1_mdata,
        output tx0_valid, tx0_addr, tx0_mdata,
        input  tx0_almostfull,
        output tx1_valid, tx1_addr, tx1_mdata, tx1_data,
        input  tx1_almostfull,
        input  rx0_rd_valid, rx0_wr_valid, rx0_mdata, rx0_data, rx1_wr_valid, rx1_mdata
    );

    modport master (
        output usr_rd_req_addr, usr_rd_req_mdata, usr_rd_req_en,
        input  usr_rd_req_almostfull,
        output usr_wr_req_addr, usr_wr_req_mdata, usr_wr_req_data, usr_wr_req_en,
        input  usr_wr_req_almostfull,
        input  usr_rd_rsp_valid, usr_rd_rsp_mdata, usr_rd_rsp_data,
        input  usr_wr_rsp0_valid, usr_wr_rsp0_mdata, usr_wr_rsp1_valid, usr_wr_rsp1_mdata,
        input  tx0_valid, tx0_addr, tx0_mdata,
        output tx0_almostfull,
        input  tx1_valid, tx1_addr, tx1_mdata, tx1_data,
        output tx1_almostfull,
        output rx0_rd_valid, rx0_wr_valid, rx0_mdata, rx0_data, rx1_wr_valid, rx1_mdata
    );
endinterface

// File: rtl/afu_req_shim.sv
// afu_req_shim: buffers user read/write requests in per-channel FIFOs, rebases their
// cache-line addresses, issues them to CCI TX under almostfull and an outstanding limit,
// registers CCI RX responses back to the user, and provides a quiesce/drain handshake.
// Ports:
//   clk, reset_n            : clock, synchronous active-low reset
//   rd_base, wr_base        : base cache-line addresses added to user offsets
//   quiesce_req/quiesce_ack : drain request / fully drained acknowledge
//   err                     : sticky push-while-full or outstanding-count underflow
//   perf_rd_cnt/perf_stall_cnt : performance counters (tied to 0 unless enabled)
//   bus                     : afu_req_shim_if.slave user and CCI signals
// Optional feature: define REQ_SHIM_PERF_EN to build the performance counters.
module afu_req_shim #(
    parameter int unsigned ADDR_LMT    = 20,
    parameter int unsigned MDATA       = 14,
    parameter int unsigned CACHE_WIDTH = 512,
    parameter int unsigned FIFO_LOG2   = 3,
    parameter int unsigned AF_SLACK    = 2,
    parameter int unsigned MAX_OUT     = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] rd_base,
    input  logic [31:0] wr_base,
    input  logic        quiesce_req,
    output logic        quiesce_ack,
    output logic        err,
    output logic [31:0] perf_rd_cnt,
    output logic [31:0] perf_stall_cnt,
    afu_req_shim_if.slave bus
);
    localparam int unsigned DEPTH = 1 << FIFO_LOG2;
    localparam int unsigned PW    = FIFO_LOG2 + 1;
    localparam int unsigned RD_W  = ADDR_LMT + MDATA;
    localparam int unsigned WR_W  = ADDR_LMT + MDATA + CACHE_WIDTH;
    localparam int unsigned OW    = 9;
    localparam logic [PW-1:0] AF_THR    = PW'(DEPTH - AF_SLACK);
    localparam logic [PW-1:0] FULL_C    = PW'(DEPTH);
    localparam logic [7:0]    MAX_OUT_C = 8'(MAX_OUT);

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_WAIT_RSP, ST_QUIESCED} state_t;

    logic [RD_W-1:0] rd_mem [DEPTH];
    logic [WR_W-1:0] wr_mem [DEPTH];

    logic [FIFO_LOG2-1:0] rd_wp_q, rd_wp_d, rd_rp_q, rd_rp_d;
    logic [FIFO_LOG2-1:0] wr_wp_q, wr_wp_d, wr_rp_q, wr_rp_d;
    logic [PW-1:0]        rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
    logic [7:0]           rd_out_q, rd_out_d, wr_out_q, wr_out_d;
    state_t               state_q, state_d;

    logic                   tx0_valid_q, tx0_valid_d, tx1_valid_q, tx1_valid_d;
    logic [31:0]            tx0_addr_q, tx0_addr_d, tx1_addr_q, tx1_addr_d;
    logic [MDATA-1:0]       tx0_mdata_q, tx0_mdata_d, tx1_mdata_q, tx1_mdata_d;
    logic [CACHE_WIDTH-1:0] tx1_data_q, tx1_data_d;

    logic                   rd_rsp_valid_q, wr_rsp0_valid_q, wr_rsp1_valid_q;
    logic [MDATA-1:0]       rd_rsp_mdata_q, wr_rsp0_mdata_q, wr_rsp1_mdata_q;
    logic [CACHE_WIDTH-1:0] rd_rsp_data_q;

    logic af_rd_q, af_rd_d, af_wr_q, af_wr_d;
    logic ack_q, ack_d, err_q, err_d;

    logic            rd_push, rd_pop, wr_push, wr_pop, idle;
    logic [RD_W-1:0] rd_head;
    logic [WR_W-1:0] wr_head;
    logic [OW-1:0]   rd_sum, rd_dec, wr_sum, wr_dec;
    logic            rd_unf, wr_unf;

    // Channel handshake: push needs space, pop needs data, CCI room and outstanding credit.
    always_comb begin
        rd_push = bus.usr_rd_req_en && (rd_cnt_q != FULL_C);
        wr_push = bus.usr_wr_req_en && (wr_cnt_q != FULL_C);
        rd_pop  = (rd_cnt_q != '0) && !bus.tx0_almostfull && (rd_out_q < MAX_OUT_C);
        wr_pop  = (wr_cnt_q != '0) && !bus.tx1_almostfull && (wr_out_q < MAX_OUT_C);
        rd_head = rd_mem[rd_rp_q];
        wr_head = wr_mem[wr_rp_q];
        // Nothing buffered, nothing on TX and nothing arriving this cycle.
        idle    = (rd_cnt_q == '0) && (wr_cnt_q == '0) && !tx0_valid_q && !tx1_valid_q
                  && !bus.usr_rd_req_en && !bus.usr_wr_req_en;
    end

    // FIFO pointers, TX request registers and outstanding accounting.
    always_comb begin
        rd_wp_d     = rd_push ? rd_wp_q + FIFO_LOG2'(1) : rd_wp_q;
        wr_wp_d     = wr_push ? wr_wp_q + FIFO_LOG2'(1) : wr_wp_q;
        rd_rp_d     = rd_pop ? rd_rp_q + FIFO_LOG2'(1) : rd_rp_q;
        wr_rp_d     = wr_pop ? wr_rp_q + FIFO_LOG2'(1) : wr_rp_q;
        rd_cnt_d    = rd_cnt_q + PW'(rd_push) - PW'(rd_pop);
        wr_cnt_d    = wr_cnt_q + PW'(wr_push) - PW'(wr_pop);

        tx0_valid_d = rd_pop;
        tx0_addr_d  = tx0_addr_q;
        tx0_mdata_d = tx0_mdata_q;
        if (rd_pop) begin
            tx0_addr_d  = rd_base + 32'(rd_head[RD_W-1:MDATA]);
            tx0_mdata_d = rd_head[MDATA-1:0];
        end
        tx1_valid_d = wr_pop;
        tx1_addr_d  = tx1_addr_q;
        tx1_mdata_d = tx1_mdata_q;
        tx1_data_d  = tx1_data_q;
        if (wr_pop) begin
            tx1_addr_d  = wr_base + 32'(wr_head[WR_W-1 -: ADDR_LMT]);
            tx1_mdata_d = wr_head[CACHE_WIDTH +: MDATA];
            tx1_data_d  = wr_head[CACHE_WIDTH-1:0];
        end

        // Net increment/decrement, saturating at zero on underflow.
        rd_sum   = OW'(rd_out_q) + OW'(rd_pop);
        rd_dec   = OW'(bus.rx0_rd_valid);
        rd_unf   = rd_sum < rd_dec;
        rd_out_d = rd_unf ? '0 : 8'(rd_sum - rd_dec);
        wr_sum   = OW'(wr_out_q) + OW'(wr_pop);
        wr_dec   = OW'(bus.rx0_wr_valid) + OW'(bus.rx1_wr_valid);
        wr_unf   = wr_sum < wr_dec;
        wr_out_d = wr_unf ? '0 : 8'(wr_sum - wr_dec);

        err_d = err_q || (bus.usr_rd_req_en && !rd_push) || (bus.usr_wr_req_en && !wr_push)
                || rd_unf || wr_unf;
    end

    // Quiesce FSM next state; ack and almostfull follow the next state so they move with it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:      if (quiesce_req) state_d = ST_DRAIN;
            ST_DRAIN:    if (!quiesce_req) state_d = ST_RUN;
                         else if (idle) state_d = ST_WAIT_RSP;
            ST_WAIT_RSP: if (!quiesce_req) state_d = ST_RUN;
                         else if (idle && (rd_out_q == '0) && (wr_out_q == '0)) state_d = ST_QUIESCED;
            ST_QUIESCED: if (!quiesce_req) state_d = ST_RUN;
            default:     state_d = ST_RUN;
        endcase
        ack_d   = (state_d == ST_QUIESCED);
        af_rd_d = (rd_cnt_d >= AF_THR) || (state_d != ST_RUN);
        af_wr_d = (wr_cnt_d >= AF_THR) || (state_d != ST_RUN);
    end

    // FIFO storage; contents need no reset because the pointers are cleared.
    always_ff @(posedge clk) begin
        if (rd_push) rd_mem[rd_wp_q] <= {bus.usr_rd_req_addr, bus.usr_rd_req_mdata};
        if (wr_push) wr_mem[wr_wp_q] <= {bus.usr_wr_req_addr, bus.usr_wr_req_mdata, bus.usr_wr_req_data};
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_wp_q <= '0; rd_rp_q <= '0; wr_wp_q <= '0; wr_rp_q <= '0;
            rd_cnt_q <= '0; wr_cnt_q <= '0; rd_out_q <= '0; wr_out_q <= '0;
            state_q <= ST_RUN;
            tx0_valid_q <= 1'b0; tx0_addr_q <= '0; tx0_mdata_q <= '0;
            tx1_valid_q <= 1'b0; tx1_addr_q <= '0; tx1_mdata_q <= '0; tx1_data_q <= '0;
            rd_rsp_valid_q <= 1'b0; rd_rsp_mdata_q <= '0; rd_rsp_data_q <= '0;
            wr_rsp0_valid_q <= 1'b0; wr_rsp0_mdata_q <= '0;
            wr_rsp1_valid_q <= 1'b0; wr_rsp1_mdata_q <= '0;
            af_rd_q <= 1'b0; af_wr_q <= 1'b0; ack_q <= 1'b0; err_q <= 1'b0;
        end else begin
            rd_wp_q <= rd_wp_d; rd_rp_q <= rd_rp_d; wr_wp_q <= wr_wp_d; wr_rp_q <= wr_rp_d;
            rd_cnt_q <= rd_cnt_d; wr_cnt_q <= wr_cnt_d; rd_out_q <= rd_out_d; wr_out_q <= wr_out_d;
            state_q <= state_d;
            tx0_valid_q <= tx0_valid_d; tx0_addr_q <= tx0_addr_d; tx0_mdata_q <= tx0_mdata_d;
            tx1_valid_q <= tx1_valid_d; tx1_addr_q <= tx1_addr_d; tx1_mdata_q <= tx1_mdata_d;
            tx1_data_q <= tx1_data_d;
            rd_rsp_valid_q <= bus.rx0_rd_valid; rd_rsp_mdata_q <= bus.rx0_mdata;
            rd_rsp_data_q <= bus.rx0_data;
            wr_rsp0_valid_q <= bus.rx0_wr_valid; wr_rsp0_mdata_q <= bus.rx0_mdata;
            wr_rsp1_valid_q <= bus.rx1_wr_valid; wr_rsp1_mdata_q <= bus.rx1_mdata;
            af_rd_q <= af_rd_d; af_wr_q <= af_wr_d; ack_q <= ack_d; err_q <= err_d;
        end
    end

`ifdef REQ_SHIM_PERF_EN
    logic [31:0] perf_rd_q, perf_rd_d, perf_stall_q, perf_stall_d;

    // Issues on tx0, and cycles with queued work held back by almostfull or credit.
    always_comb begin
        perf_rd_d    = perf_rd_q + 32'(rd_pop);
        perf_stall_d = perf_stall_q
                       + 32'(((rd_cnt_q != '0) && !rd_pop) || ((wr_cnt_q != '0) && !wr_pop));
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            perf_rd_q    <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_rd_q    <= perf_rd_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_rd_cnt    = perf_rd_q;
    assign perf_stall_cnt = perf_stall_q;
`else
    assign perf_rd_cnt    = '0;
    assign perf_stall_cnt = '0;
`endif

    assign bus.usr_rd_req_almostfull = af_rd_q;
    assign bus.usr_wr_req_almostfull = af_wr_q;
    assign bus.usr_rd_rsp_valid      = rd_rsp_valid_q;
    assign bus.usr_rd_rsp_mdata      = rd_rsp_mdata_q;
    assign bus.usr_rd_rsp_data       = rd_rsp_data_q;
    assign bus.usr_wr_rsp0_valid     = wr_rsp0_valid_q;
    assign bus.usr_wr_rsp0_mdata     = wr_rsp0_mdata_q;
    assign bus.usr_wr_rsp1_valid     = wr_rsp1_valid_q;
    assign bus.usr_wr_rsp1_mdata     = wr_rsp1_mdata_q;
    assign bus.tx0_valid             = tx0_valid_q;
    assign bus.tx0_addr              = tx0_addr_q;
    assign bus.tx0_mdata             = tx0_mdata_q;
    assign bus.tx1_valid             = tx1_valid_q;
    assign bus.tx1_addr              = tx1_addr_q;
    assign bus.tx1_mdata             = tx1_mdata_q;
    assign bus.tx1_data              = tx1_data_q;
    assign quiesce_ack               = ack_q;
    assign err                       = err_q;
endmodule
